fifo4_ctrl: RTL and testbench

- Synchronous FIFO controller that sequences the 4-entry x 64-bit register buffer as a circular queue.
- Upstream and downstream sides use valid/ready handshakes. The controller generates the buffer write address, write enable and read address.
- Output is first-word-fall-through: read data is combinational from the buffer at the read pointer.
- Sits between the producer and consumer stages of the pipelined ALU/cache path.

---
 rtl/fifo4_ctrl.sv | 80 ++++++++
 tb/tb_fifo4_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fifo4_ctrl.sv
// Pointer/occupancy controller for a 4-entry register buffer run as a first-word-fall-through queue.
// Upstream and downstream use valid/ready; in_ready never depends on out_ready.
module fifo4_ctrl #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 2,
  parameter int AFULL_LVL = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] buf_w_addr,
  output logic [DATA_W-1:0] buf_w_data,
  output logic              buf_w_enable,
  output logic [ADDR_W-1:0] buf_r_addr,
  input  logic [DATA_W-1:0] buf_r_data,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
  output logic [ADDR_W:0]   high_water
);

  localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AFULL_THR = AFULL_LVL[ADDR_W:0];

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] count_nxt;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;

  // The extra MSB on each pointer is the wrap bit that tells full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  assign in_ready  = !full && !rst && !flush;
  assign out_valid = !empty && !rst && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign buf_w_enable = push;
  assign buf_w_addr   = wr_ptr[ADDR_W-1:0];
  assign buf_w_data   = in_data;
  assign buf_r_addr   = rd_ptr[ADDR_W-1:0];
  assign out_data     = buf_r_data;

  assign almost_full = (count >= AFULL_THR);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + PTR_ONE;
      2'b01:   count_nxt = count - PTR_ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      high_water <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      // count_nxt never exceeds the depth, so the peak saturates by construction.
      if (count_nxt > high_water) high_water <= count_nxt;
    end
  end

endmodule

// File: tb/tb_fifo4_ctrl.sv
// Directed bench for fifo4_ctrl with a behavioural 4x64 register buffer attached.
module tb_fifo4_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid, buf_w_enable, almost_full;
  logic [63:0] in_data, out_data, buf_w_data, buf_r_data;
  logic [1:0]  buf_w_addr, buf_r_addr;
  logic [2:0]  count, high_water;
  logic [63:0] mem [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (buf_w_enable) mem[buf_w_addr] <= buf_w_data;
  assign buf_r_data = mem[buf_r_addr];

  fifo4_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .buf_w_addr(buf_w_addr), .buf_w_data(buf_w_data), .buf_w_enable(buf_w_enable),
    .buf_r_addr(buf_r_addr), .buf_r_data(buf_r_data),
    .count(count), .almost_full(almost_full), .high_water(high_water)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during_rst: got %b exp 0", in_ready); end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL idle_count[%0d]: got %0d exp 0", i, count); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid[%0d]: got %b exp 0", i, out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready[%0d]: got %b exp 1", i, in_ready); end
      checks++; if (high_water !== 3'd0) begin errors++; $display("FAIL idle_high_water[%0d]: got %0d exp 0", i, high_water); end
      checks++; if (buf_w_enable !== 1'b0) begin errors++; $display("FAIL idle_w_enable[%0d]: got %b exp 0", i, buf_w_enable); end
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL idle_almost_full[%0d]: got %b exp 0", i, almost_full); end
      tick();
    end
  endtask

  task automatic test_fill;
    logic [2:0] exp_cnt;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 64'hA0 + 64'(i);
      #1;
      checks++; if (buf_w_enable !== 1'b1) begin errors++; $display("FAIL fill_w_enable[%0d]: got %b exp 1", i, buf_w_enable); end
      checks++; if (buf_w_addr !== 2'(i)) begin errors++; $display("FAIL fill_w_addr[%0d]: got %0d exp %0d", i, buf_w_addr, i); end
      tick();
      exp_cnt = 3'(i + 1);
      checks++; if (count !== exp_cnt) begin errors++; $display("FAIL fill_count[%0d]: got %0d exp %0d", i, count, exp_cnt); end
      checks++; if (almost_full !== (exp_cnt >= 3'd3)) begin errors++; $display("FAIL fill_almost_full[%0d]: got %b exp %b", i, almost_full, exp_cnt >= 3'd3); end
    end
    in_data = 64'hA4;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b exp 0", in_ready); end
    checks++; if (buf_w_enable !== 1'b0) begin errors++; $display("FAIL full_w_enable: got %b exp 0", buf_w_enable); end
    tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count_hold: got %0d exp 4", count); end
    in_valid = 1'b0;
  endtask

  task automatic test_drain;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready_with_out_ready: got %b exp 0", in_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_out_valid[%0d]: got %b exp 1", i, out_valid); end
      checks++; if (out_data !== 64'hA0 + 64'(i)) begin errors++; $display("FAIL drain_out_data[%0d]: got %h exp %h", i, out_data, 64'hA0 + 64'(i)); end
      tick();
      if (i == 0) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL after_pop_in_ready: got %b exp 1", in_ready); end
      end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty_out_valid: got %b exp 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count: got %0d exp 0", count); end
    checks++; if (high_water !== 3'd4) begin errors++; $display("FAIL drain_high_water: got %0d exp 4", high_water); end
    // out_ready on an empty queue must not move anything
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL empty_pop_count: got %0d exp 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    in_valid = 1'b1; in_data = 64'h00; out_ready = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      in_valid = (i < 19); in_data = 64'(i + 1); out_ready = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid[%0d]: got %b exp 1", i, out_valid); end
      checks++; if (out_data !== 64'(i)) begin errors++; $display("FAIL b2b_out_data[%0d]: got %h exp %h", i, out_data, 64'(i)); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_count[%0d]: got %0d exp 1", i, count); end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_final_count: got %0d exp 0", count); end
    checks++; if (high_water !== 3'd4) begin errors++; $display("FAIL b2b_high_water: got %0d exp 4", high_water); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 64'hB0 + 64'(i);
      tick();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d exp 3", count); end
    flush = 1'b1; in_data = 64'hBF; out_ready = 1'b1;
    #1;
    checks++; if (buf_w_enable !== 1'b0) begin errors++; $display("FAIL flush_w_enable: got %b exp 0", buf_w_enable); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b exp 0", out_valid); end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d exp 0", count); end
    checks++; if (high_water !== 3'd0) begin errors++; $display("FAIL flush_high_water: got %0d exp 0", high_water); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_post_out_valid: got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_post_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 64'hC0 + 64'(i);
      tick();
    end
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 64'hCF;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready: got %b exp 0", in_ready); end
    checks++; if (buf_w_enable !== 1'b0) begin errors++; $display("FAIL rst_mid_w_enable: got %b exp 0", buf_w_enable); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b exp 0", out_valid); end
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_mid_count: got %0d exp 0", count); end
    checks++; if (high_water !== 3'd0) begin errors++; $display("FAIL rst_mid_high_water: got %0d exp 0", high_water); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_post_out_valid: got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_post_in_ready: got %b exp 1", in_ready); end
    in_valid = 1'b1; in_data = 64'hD5;
    #1;
    checks++; if (buf_w_addr !== 2'd0) begin errors++; $display("FAIL rst_mid_w_addr: got %0d exp 0", buf_w_addr); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_readback_valid: got %b exp 1", out_valid); end
    checks++; if (out_data !== 64'hD5) begin errors++; $display("FAIL rst_mid_readback_data: got %h exp d5", out_data); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL rst_mid_readback_count: got %0d exp 1", count); end
    checks++; if (high_water !== 3'd1) begin errors++; $display("FAIL rst_mid_readback_hw: got %0d exp 1", high_water); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_mid_final_count: got %0d exp 0", count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
